param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_pkg.sv | 29 ++
 rtl/param_fifo_mem.sv | 40 ++++
 rtl/param_fifo.sv | 147 ++++++++++++++
 tb/tb_param_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared constants and helpers for the param_fifo block.
// Build option: PARAM_FIFO_ERR_FLAGS_EN enables the sticky overflow/underflow flags.
package param_fifo_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 256;
    localparam int unsigned DEF_AF_MARGIN = 4;
    localparam int unsigned DEF_AE_LEVEL  = 4;

    // Bit positions inside the internal status-flag vector.
    localparam int unsigned FLAG_FULL   = 0;
    localparam int unsigned FLAG_EMPTY  = 1;
    localparam int unsigned FLAG_AFULL  = 2;
    localparam int unsigned FLAG_AEMPTY = 3;
    localparam int unsigned FLAG_W      = 4;

    // Ceiling log2; used for pointer width (count is one bit wider).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// fifo_mem: simple dual-port storage, one write port, one registered read port.
module fifo_mem
    import param_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage array: written on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register: loads only on an accepted read, otherwise holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with occupancy count and status flags.
// Build option: PARAM_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags;
// without it both outputs are constant 0.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
    localparam int unsigned AW      = clog2(DEPTH),
    localparam int unsigned CW      = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_acc, rd_acc;
    logic [FLAG_W-1:0] flags;

    // Status flags, all derived from the registered count.
    always_comb begin
        flags              = '0;
        flags[FLAG_FULL]   = (32'(count_q) == DEPTH);
        flags[FLAG_EMPTY]  = (count_q == '0);
        flags[FLAG_AFULL]  = (32'(count_q) >= AF_LEVEL);
        flags[FLAG_AEMPTY] = (32'(count_q) <= AE_LEVEL);
    end

    // Handshake: reads need data already stored (no bypass); a write into a
    // full FIFO is allowed only when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc = rd_en && !flags[FLAG_EMPTY] && !clear;
        wr_acc = wr_en && (!flags[FLAG_FULL] || rd_acc) && !clear;
    end

    // Next-state for pointers, count and read-valid; clear overrides everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_acc;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = flags[FLAG_FULL];
    assign empty        = flags[FLAG_EMPTY];
    assign almost_full  = flags[FLAG_AFULL];
    assign almost_empty = flags[FLAG_AEMPTY];

`ifdef PARAM_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set on rejected requests, cleared only by rst/clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en && !wr_acc)            overflow_d  = 1'b1;
            if (rd_en && flags[FLAG_EMPTY])  underflow_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (DEPTH=8, DATA_W=8, AF=4, AE=4).
// Honours PARAM_FIFO_ERR_FLAGS_EN for the expected overflow/underflow values.
module tb_param_fifo;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AF = 4;
    localparam int AE = 4;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          clear;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    param_fifo #(
        .DATA_W   (DW),
        .DEPTH    (DP),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the observable registers.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd_data = '0;
    logic          m_rd_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_rd_valid <= 1'b0;
            m_rd_data  <= '0;
            m_ovf      <= 1'b0;
            m_unf      <= 1'b0;
        end else if (clear) begin
            mq.delete();
            m_rd_valid <= 1'b0;
            m_ovf      <= 1'b0;
            m_unf      <= 1'b0;
        end else begin
            automatic int occ   = mq.size();
            automatic bit rd_ok = rd_en && (occ > 0);
            automatic bit wr_ok = wr_en && ((occ < DP) || rd_ok);
            m_rd_valid <= rd_ok;
            if (rd_ok) m_rd_data <= mq.pop_front();
            if (wr_ok) mq.push_back(wr_data);
            if (wr_en && !wr_ok) m_ovf <= ERR_EN;
            if (rd_en && occ == 0) m_unf <= ERR_EN;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic int occ = mq.size();
            chk("count", int'(count), occ);
            chk("empty", int'(empty), int'(occ == 0));
            chk("full", int'(full), int'(occ == DP));
            chk("almost_full", int'(almost_full), int'(occ >= AF));
            chk("almost_empty", int'(almost_empty), int'(occ <= AE));
            chk("rd_valid", int'(rd_valid), int'(m_rd_valid));
            chk("rd_data", int'(rd_data), int'(m_rd_data));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_unf));
        end
    end

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clear   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #1 rst = 1'b1;
        #2;
        // Reset state.
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_aempty", int'(almost_empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_afull", int'(almost_full), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Basic write/read; first edge after reset release accepts the write.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("first_write_count", int'(count), 1);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("basic_rd0_valid", int'(rd_valid), 1);
        chk("basic_rd0_data", int'(rd_data), 8'h11);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("basic_rd1_data", int'(rd_data), 8'h22);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("basic_rd2_data", int'(rd_data), 8'h33);
        chk("basic_count", int'(count), 0);
        chk("basic_empty", int'(empty), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("basic_valid_drop", int'(rd_valid), 0);
        chk("basic_data_hold", int'(rd_data), 8'h33);

        // Fill to full, then a rejected ninth write.
        for (int i = 0; i < DP; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_afull", int'(almost_full), 1);
        chk("fill_count", int'(count), 8);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_count", int'(count), 8);
        chk("ovf_flag", int'(overflow), int'(ERR_EN));

        // Simultaneous read/write at full across pointer wraps.
        step(1'b1, 8'h80, 1'b1, 1'b0);
        chk("rw_first_data", int'(rd_data), 8'h40);
        for (int i = 1; i < 20; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        chk("rw_count", int'(count), 8);
        chk("rw_last_data", int'(rd_data), 8'h8B);

        // Drain to five entries, then clear together with a write.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_clear_count", int'(count), 5);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        chk("clear_count", int'(count), 0);
        chk("clear_empty", int'(empty), 1);
        chk("clear_overflow", int'(overflow), 0);
        chk("clear_rd_data", int'(rd_data), 8'h8E);

        // Read from empty with a simultaneous write.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("unf_valid", int'(rd_valid), 0);
        chk("unf_count", int'(count), 1);
        chk("unf_flag", int'(underflow), int'(ERR_EN));
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_readback", int'(rd_data), 8'hA5);

        // Reset asserted between edges while a read is in flight.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h5B, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_valid", int'(rd_valid), 1);
        chk("pre_rst_data", int'(rd_data), 8'h5A);
        #1 rst = 1'b1;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_valid", int'(rd_valid), 0);
        chk("midrst_data", int'(rd_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_valid", int'(rd_valid), 0);
        chk("post_rst_underflow", int'(underflow), 0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
